alu_issue_stage: RTL
====================

Name: alu_issue_stage

Overview:
- Pipeline stage directly upstream of the combinational ALU; buffers ALU requests and feeds the ALU's A/B/ALUOp inputs.
- Captures the ALU's C output into a registered result with valid/ready handshake toward writeback.
- Decouples the decode side from writeback backpressure: 2-entry request FIFO plus 1 result register.
- ALU stays external and combinational. This block only sequences operands into it and results out of it.

Parameters:
- TAG_W, 5, width of the destination tag carried alongside each request (GRF index).
- DEPTH, 2, request FIFO depth. Fixed at 2; other values are unsupported.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- flush  input  1  synchronous, active-high; discards all buffered requests and the pending result.
- in_valid  input  1  request present.
- in_ready  output  1  stage can accept a request this cycle.
- in_op  input  3  ALU operation code.
- in_a  input  32  operand A.
- in_b  input  32  operand B.
- in_tag  input  TAG_W  destination tag.
- alu_A  output  32  to ALU input A: FIFO head operand A, 0 when the FIFO is empty.
- alu_B  output  32  to ALU input B: FIFO head operand B, 0 when the FIFO is empty.
- alu_op  output  3  to ALU operation input: FIFO head op, 0 when the FIFO is empty.
- alu_C  input  32  ALU result, combinational from alu_A/alu_B/alu_op.
- out_valid  output  1  result register holds a valid result.
- out_ready  input  1  downstream accepts the result.
- out_data  output  32  registered result.
- out_tag  output  TAG_W  registered tag.
- out_err  output  1  result came from an illegal op (3'b110 or 3'b111).
- count  output  2  FIFO occupancy, range 0..2.

Behaviour:
- ALUOp encoding: 000 add, 001 sub, 010 and, 011 or, 100 logical right shift, 101 arithmetic right shift.
- Op codes 110 and 111 are illegal. The ALU returns 0 for them; this block sets out_err=1 for that result.
- Reset or flush: count=0, out_valid=0, out_data=0, out_tag=0, out_err=0, FIFO pointers cleared. Reset and flush have equal effect; if both are asserted, the result is the same.
- in_ready = (count != 2). It is combinational from registered state only and never depends on in_valid.
- push = in_valid & in_ready.
- pop = (count != 0) & (!out_valid | out_ready).
- On pop, the result register loads alu_C, the head tag, and err = (head op >= 6). out_valid is set to 1.
- If out_valid & out_ready with no pop, out_valid clears next cycle. out_data and out_tag hold their last values.
- Push and pop in the same cycle: count is unchanged. Push with count=0 and simultaneous pop is impossible, because pop requires count != 0.
- FIFO read/write pointers are 1 bit and wrap 1 -> 0.
- Latency: a request accepted at edge N with an empty FIFO and a free result register appears on out_valid after edge N+1.
- Throughput: 1 result per cycle while out_ready=1.
- Backpressure capacity: up to 3 requests in flight (2 in the FIFO, 1 in the result register). With out_ready=0 and all 3 slots full, in_ready=0.
- Flush or reset asserted mid-handshake: any push or pop in that cycle is discarded. Nothing is committed.
- No combinational path from in_* to out_*. Paths from out_ready to in_ready do not exist; in_ready changes only after an edge.

Test Plan:
- Reset then idle -> count=0, out_valid=0, out_data=0, in_ready=1, alu_A=alu_B=0.
- Push op=000, a=5, b=3, tag=7; out_ready=1 -> one cycle later out_valid=1, out_data=8, out_tag=7, out_err=0.
- Push op=001 a=3 b=5, then op=101 a=0x80000000 b=4 on consecutive cycles -> out_data=0xFFFFFFFE, then 0xF8000000 on back-to-back cycles.
- Backpressure: out_ready=0, push 4 requests back-to-back -> in_ready=0 after the 3rd accept and the 4th is held. Then raise out_ready -> results emerge in push order, 1 per cycle, with no loss or duplication.
- Push op=110 a=1 b=1 -> out_data=0, out_err=1. A following op=010 a=0xF0 b=0x3C gives out_data=0x30, out_err=0.
- Fill to count=2 with out_valid=1, then assert reset (and separately flush) for 1 cycle with in_valid=1 -> next cycle count=0, out_valid=0, and the pushed request is dropped.

Source files
------------

// File: rtl/alu_issue_stage.sv
// Issue stage in front of a combinational ALU: 2-entry request FIFO feeding the
// ALU operand/op inputs, and a result register handing C to writeback.
module alu_issue_stage #(
  parameter int TAG_W = 5,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      alu_A,
  output logic [31:0]      alu_B,
  output logic [2:0]       alu_op,
  input  logic [31:0]      alu_C,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err,
  output logic [1:0]       count
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  // Handshake: a transfer happens on an edge where valid & ready are both high;
  // valid never waits on ready, and ready here depends on registered state only.
  logic             clr;
  logic             push;
  logic             pop;
  logic             fifo_empty;

  logic [31:0]      a_mem_q   [2];
  logic [31:0]      b_mem_q   [2];
  logic [2:0]       op_mem_q  [2];
  logic [TAG_W-1:0] tag_mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic [1:0]       count_d;

  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_data_q,  out_data_d;
  logic [TAG_W-1:0] out_tag_q,   out_tag_d;
  logic             out_err_q,   out_err_d;

  assign clr        = reset | flush;
  assign fifo_empty = (count_q == 2'd0);
  assign in_ready   = (count_q != FULL);
  assign push       = in_valid & in_ready;
  assign pop        = !fifo_empty & (!out_valid_q | out_ready);

  assign alu_A  = fifo_empty ? 32'd0 : a_mem_q[rd_ptr_q];
  assign alu_B  = fifo_empty ? 32'd0 : b_mem_q[rd_ptr_q];
  assign alu_op = fifo_empty ? 3'd0  : op_mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        a_mem_q[i]   <= '0;
        b_mem_q[i]   <= '0;
        op_mem_q[i]  <= '0;
        tag_mem_q[i] <= '0;
      end
    end else begin
      if (push) begin
        a_mem_q[wr_ptr_q]   <= in_a;
        b_mem_q[wr_ptr_q]   <= in_b;
        op_mem_q[wr_ptr_q]  <= in_op;
        tag_mem_q[wr_ptr_q] <= in_tag;
        wr_ptr_q            <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  // Data and tag hold their last values after the result is consumed.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_tag_d   = out_tag_q;
    out_err_d   = out_err_q;
    if (pop) begin
      out_valid_d = 1'b1;
      out_data_d  = alu_C;
      out_tag_d   = tag_mem_q[rd_ptr_q];
      out_err_d   = (op_mem_q[rd_ptr_q][2:1] == 2'b11);
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
      out_err_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_tag_q   <= out_tag_d;
      out_err_q   <= out_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;
  assign out_err   = out_err_q;
  assign count     = count_q;

endmodule
